dcache_lookup_port: RTL and testbench
=====================================

// Module: dcache_lookup_port
// PURPOSE
// Requester-side engine for one port of the set-associative data-cache tag/data arbiter.
// Accepts a load lookup (index first, tag one cycle later) and issues an all-ways read to the arbiter.
// Compares against the arbiter's per-way hit vector and returns the addressed word on a hit.
// On a miss, hands the line to the miss unit, waits for the refill, then replays the lookup.
// PARAMETERS
// SET_ASSOC   8    number of ways (req_o width, hit_way_i width)
// ADDR_WIDTH  12   index+offset width presented to the arbiter
// TAG_WIDTH   44   physical tag width
// LINE_WIDTH  128  cache line data bits per way
// DATA_WIDTH  64   returned word width; LINE_WIDTH/DATA_WIDTH is a power of 2, >=1
// PORTS
// clk_i         in   1                      clock
// rst_ni        in   1                      async reset, active low
// flush_i       in   1                      sync clear: abort everything, return to IDLE
// lu_req_i      in   1                      lookup request, held until lu_gnt_o
// lu_gnt_o      out  1                      lookup accepted this cycle
// lu_addr_i     in   ADDR_WIDTH             index+byte offset of lookup
// lu_tag_i      in   TAG_WIDTH              tag, valid cycle after grant when lu_tag_valid_i
// lu_tag_valid_i in  1                      lu_tag_i valid
// lu_kill_i     in   1                      abandon accepted lookup (no rvalid)
// lu_rvalid_o   out  1                      one-cycle pulse: lu_rdata_o valid (hit)
// lu_rdata_o    out  DATA_WIDTH             hit word
// req_o         out  SET_ASSOC              per-way read request to arbiter
// gnt_i         in   1                      arbiter grant
// addr_o        out  ADDR_WIDTH             address to arbiter
// tag_o         out  TAG_WIDTH              tag to arbiter, cycle after grant
// rdata_i       in   SET_ASSOC*LINE_WIDTH   per-way line data, cycle after grant
// hit_way_i     in   SET_ASSOC              per-way hit, cycle after grant
// miss_req_o    out  1                      miss request, held until miss_gnt_i
// miss_gnt_i    in   1                      miss unit accepted
// miss_addr_o   out  TAG_WIDTH+ADDR_WIDTH   {tag, addr} of missing line
// miss_done_i   in   1                      refill complete pulse
// BEHAVIOUR
// - Reset/flush: state IDLE, all outputs 0, captured addr/tag/kill flag cleared. Flush overrides everything same cycle.
// - States: IDLE, COMPARE, TAG_WAIT, MISS_REQ, WAIT_REFILL, REPLAY.
// - IDLE: req_o = {SET_ASSOC{lu_req_i}}, addr_o = lu_addr_i, lu_gnt_o = lu_req_i & gnt_i. On grant capture addr -> COMPARE.
//   No grant: stay; requester holds request stable.
// - lu_gnt_o is 0 in every state except IDLE; no back-to-back lookups.
// - COMPARE (cycle after grant): tag_o = replay ? stored tag : lu_tag_i.
//   kill -> IDLE, no outputs.
//   First pass with !lu_tag_valid_i -> TAG_WAIT (array data dropped).
//   Hit (|hit_way_i) -> lu_rvalid_o=1 this cycle, then IDLE.
//   Miss -> store tag, MISS_REQ.
// - Hit data: way = lowest set bit of hit_way_i. Word = bits [LINE_WIDTH/DATA_WIDTH-1:0] selection by addr[log2(LINE_WIDTH/8)-1:log2(DATA_WIDTH/8)].
//   Hit latency = 1 cycle after grant.
// - TAG_WAIT: on lu_tag_valid_i store tag -> REPLAY. kill -> IDLE.
// - MISS_REQ: miss_req_o=1, miss_addr_o={stored tag, stored addr} stable. miss_gnt_i -> WAIT_REFILL.
//   kill without gnt -> IDLE, miss_req_o drops next cycle. kill with gnt same cycle -> WAIT_REFILL, kill flag set.
// - WAIT_REFILL: kill sets kill flag. On miss_done_i: flag set -> IDLE (flag cleared), else -> REPLAY.
// - REPLAY: req_o all ones, addr_o = stored addr. On gnt_i -> COMPARE using stored tag. kill -> IDLE.
//   A replay miss (line evicted) repeats MISS_REQ; no limit.
// - lu_rdata_o = 0 whenever lu_rvalid_o = 0.
// - Sim assertion: $onehot0(hit_way_i) in COMPARE.
// TESTING
// - Hit: addr 0x048, gnt same cycle, tag 0x12 valid next cycle, hit_way=0x04, way2 line={W1,W0} -> rvalid 1 cycle after gnt, rdata=W1.
// - Grant stall: gnt_i low 3 cycles -> lu_gnt_o low 3 cycles, req_o=0xFF held, then normal hit.
// - Miss/replay: hit_way=0 -> miss_req_o with {0x12,0x048} until miss_gnt_i; miss_done_i -> req_o reissued; hit on replay -> rvalid.
// - Late tag: tag_valid low in COMPARE -> TAG_WAIT; tag 2 cycles later -> REPLAY; lookup hits using stored tag.
// - Kill in WAIT_REFILL: refill completes, no replay, no rvalid, next lookup accepted in IDLE.
// - Multi-hit 0x06: lowest way (1) selected; assertion fires. Flush mid-MISS_REQ: miss_req_o 0 next cycle, state IDLE.

Source files
------------

// File: rtl/dcache_lookup_port_if.sv
// Signal bundle between a load requester, the tag/data arbiter and the miss unit,
// seen from the lookup-port engine (master) and from its environment (slave).
interface dcache_lookup_port_if #(
  parameter int SET_ASSOC  = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 44,
  parameter int LINE_WIDTH = 128,
  parameter int DATA_WIDTH = 64
);
  logic                            lu_req_i;
  logic                            lu_gnt_o;
  logic [ADDR_WIDTH-1:0]           lu_addr_i;
  logic [TAG_WIDTH-1:0]            lu_tag_i;
  logic                            lu_tag_valid_i;
  logic                            lu_kill_i;
  logic                            lu_rvalid_o;
  logic [DATA_WIDTH-1:0]           lu_rdata_o;
  logic [SET_ASSOC-1:0]            req_o;
  logic                            gnt_i;
  logic [ADDR_WIDTH-1:0]           addr_o;
  logic [TAG_WIDTH-1:0]            tag_o;
  logic [SET_ASSOC*LINE_WIDTH-1:0] rdata_i;
  logic [SET_ASSOC-1:0]            hit_way_i;
  logic                            miss_req_o;
  logic                            miss_gnt_i;
  logic [TAG_WIDTH+ADDR_WIDTH-1:0] miss_addr_o;
  logic                            miss_done_i;

  modport master (
    input  lu_req_i, lu_addr_i, lu_tag_i, lu_tag_valid_i, lu_kill_i,
    input  gnt_i, rdata_i, hit_way_i, miss_gnt_i, miss_done_i,
    output lu_gnt_o, lu_rvalid_o, lu_rdata_o, req_o, addr_o, tag_o,
    output miss_req_o, miss_addr_o
  );

  modport slave (
    output lu_req_i, lu_addr_i, lu_tag_i, lu_tag_valid_i, lu_kill_i,
    output gnt_i, rdata_i, hit_way_i, miss_gnt_i, miss_done_i,
    input  lu_gnt_o, lu_rvalid_o, lu_rdata_o, req_o, addr_o, tag_o,
    input  miss_req_o, miss_addr_o
  );
endinterface

// File: rtl/dcache_lookup_port.sv
// One requester port of the set-associative data cache: issues all-way reads,
// returns the hit word, and on a miss hands off to the miss unit and replays.
module dcache_lookup_port #(
  parameter int SET_ASSOC  = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 44,
  parameter int LINE_WIDTH = 128,
  parameter int DATA_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  dcache_lookup_port_if.master bus
);

  localparam int WORDS  = LINE_WIDTH / DATA_WIDTH;
  localparam int OFF_LO = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE, COMPARE, TAG_WAIT, MISS_REQ, WAIT_REFILL, REPLAY
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_held;
  logic [TAG_WIDTH-1:0]  tag_held;
  logic                  kill_held;
  logic                  replay_pass;

  logic [TAG_WIDTH-1:0]            cmp_tag;
  logic                            any_hit;
  logic                            tag_ok;
  logic                            lu_gnt;
  logic [SET_ASSOC-1:0]            req;
  logic [ADDR_WIDTH-1:0]           addr;
  logic [TAG_WIDTH-1:0]            tag;
  logic                            rvalid;
  logic [DATA_WIDTH-1:0]           rdata;
  logic                            miss_req;
  logic [TAG_WIDTH+ADDR_WIDTH-1:0] miss_addr;

  // Lowest hitting way wins; the word inside the line comes from the byte offset.
  function automatic logic [DATA_WIDTH-1:0] pick_word(
    input logic [SET_ASSOC*LINE_WIDTH-1:0] lines,
    input logic [SET_ASSOC-1:0]            hits,
    input logic [ADDR_WIDTH-1:0]           a
  );
    int way;
    int word;
    way = 0;
    for (int i = SET_ASSOC - 1; i >= 0; i--) begin
      if (hits[i]) way = i;
    end
    word = int'(a >> OFF_LO) & (WORDS - 1);
    return lines[way*LINE_WIDTH + word*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign cmp_tag = replay_pass ? tag_held : bus.lu_tag_i;
  assign any_hit = |bus.hit_way_i;
  assign tag_ok  = replay_pass || bus.lu_tag_valid_i;

  always_comb begin
    lu_gnt    = 1'b0;
    req       = '0;
    addr      = '0;
    tag       = '0;
    rvalid    = 1'b0;
    rdata     = '0;
    miss_req  = 1'b0;
    miss_addr = '0;
    if (rst_ni && !flush_i) begin
      unique case (state)
        IDLE: begin
          req    = {SET_ASSOC{bus.lu_req_i}};
          addr   = bus.lu_addr_i;
          lu_gnt = bus.lu_req_i & bus.gnt_i;
        end
        COMPARE: begin
          tag = cmp_tag;
          if (!bus.lu_kill_i && tag_ok && any_hit) begin
            rvalid = 1'b1;
            rdata  = pick_word(bus.rdata_i, bus.hit_way_i, addr_held);
          end
        end
        MISS_REQ: begin
          miss_req  = 1'b1;
          miss_addr = {tag_held, addr_held};
        end
        REPLAY: begin
          req  = '1;
          addr = addr_held;
        end
        default: ;
      endcase
    end
  end

  assign bus.lu_gnt_o    = lu_gnt;
  assign bus.req_o       = req;
  assign bus.addr_o      = addr;
  assign bus.tag_o       = tag;
  assign bus.lu_rvalid_o = rvalid;
  assign bus.lu_rdata_o  = rdata;
  assign bus.miss_req_o  = miss_req;
  assign bus.miss_addr_o = miss_addr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      addr_held   <= '0;
      tag_held    <= '0;
      kill_held   <= 1'b0;
      replay_pass <= 1'b0;
    end else if (flush_i) begin
      state       <= IDLE;
      addr_held   <= '0;
      tag_held    <= '0;
      kill_held   <= 1'b0;
      replay_pass <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.lu_req_i && bus.gnt_i) begin
            addr_held   <= bus.lu_addr_i;
            replay_pass <= 1'b0;
            kill_held   <= 1'b0;
            state       <= COMPARE;
          end
        end
        COMPARE: begin
          if (bus.lu_kill_i) begin
            state <= IDLE;
          end else if (!tag_ok) begin
            state <= TAG_WAIT;
          end else if (any_hit) begin
            state <= IDLE;
          end else begin
            tag_held <= cmp_tag;
            state    <= MISS_REQ;
          end
        end
        TAG_WAIT: begin
          if (bus.lu_kill_i) begin
            state <= IDLE;
          end else if (bus.lu_tag_valid_i) begin
            tag_held <= bus.lu_tag_i;
            state    <= REPLAY;
          end
        end
        // A kill racing the miss grant cannot retract the refill; remember it instead.
        MISS_REQ: begin
          if (bus.miss_gnt_i) begin
            kill_held <= bus.lu_kill_i;
            state     <= WAIT_REFILL;
          end else if (bus.lu_kill_i) begin
            state <= IDLE;
          end
        end
        WAIT_REFILL: begin
          if (bus.miss_done_i) begin
            kill_held <= 1'b0;
            state     <= (kill_held || bus.lu_kill_i) ? IDLE : REPLAY;
          end else if (bus.lu_kill_i) begin
            kill_held <= 1'b1;
          end
        end
        REPLAY: begin
          if (bus.lu_kill_i) begin
            state <= IDLE;
          end else if (bus.gnt_i) begin
            replay_pass <= 1'b1;
            state       <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  no_multi_hit: assert property (
    @(posedge clk_i) disable iff (!rst_ni || flush_i)
    (state == COMPARE) |-> $onehot0(bus.hit_way_i)
  ) else $warning("dcache_lookup_port: multi-way hit 0x%0h, lowest way taken", bus.hit_way_i);

endmodule

// File: tb/tb_dcache_lookup_port.sv
// Directed bench for dcache_lookup_port: a table of single lookups plus
// hand-written stall, miss/replay, late-tag, kill and flush sequences.
module tb_dcache_lookup_port;
  localparam int SA = 8;
  localparam int AW = 12;
  localparam int TW = 44;
  localparam int LW = 128;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  dcache_lookup_port_if #(.SET_ASSOC(SA), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                          .LINE_WIDTH(LW), .DATA_WIDTH(DW)) bus ();

  dcache_lookup_port #(.SET_ASSOC(SA), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                       .LINE_WIDTH(LW), .DATA_WIDTH(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus.master)
  );

  typedef struct {
    logic [AW-1:0]    addr;
    logic [TW-1:0]    tag;
    logic [SA-1:0]    hit;
    logic             rvalid;
    logic [DW-1:0]    rdata;
    logic [TW+AW-1:0] maddr;
  } vec_t;

  vec_t vecs[7];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Word k of way w reads back as DA7A_..._00wk.
  function automatic logic [SA*LW-1:0] lines_fill();
    logic [SA*LW-1:0] l;
    l = '0;
    for (int w = 0; w < SA; w++)
      for (int k = 0; k < LW / DW; k++)
        l[w*LW + k*DW +: DW] = 64'hDA7A_0000_0000_0000 | 64'(w * 16 + k);
    return l;
  endfunction

  task automatic clear_in();
    bus.lu_req_i       = 1'b0;
    bus.lu_addr_i      = '0;
    bus.lu_tag_i       = '0;
    bus.lu_tag_valid_i = 1'b0;
    bus.lu_kill_i      = 1'b0;
    bus.gnt_i          = 1'b0;
    bus.hit_way_i      = '0;
    bus.miss_gnt_i     = 1'b0;
    bus.miss_done_i    = 1'b0;
  endtask

  task automatic grant_lookup(input string nm, input logic [AW-1:0] a);
    @(negedge clk);
    clear_in();
    bus.lu_req_i  = 1'b1;
    bus.lu_addr_i = a;
    bus.gnt_i     = 1'b1;
    #1;
    chk({nm, "_lu_gnt"}, 64'(bus.lu_gnt_o), 64'd1);
    chk({nm, "_req"}, 64'(bus.req_o), 64'hFF);
    chk({nm, "_addr"}, 64'(bus.addr_o), 64'(a));
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string nm;
    nm = $sformatf("v%0d", i);
    grant_lookup(nm, v.addr);
    @(negedge clk);
    clear_in();
    bus.lu_tag_i       = v.tag;
    bus.lu_tag_valid_i = 1'b1;
    bus.hit_way_i      = v.hit;
    #1;
    chk({nm, "_tag_o"}, 64'(bus.tag_o), 64'(v.tag));
    chk({nm, "_rvalid"}, 64'(bus.lu_rvalid_o), 64'(v.rvalid));
    chk({nm, "_rdata"}, 64'(bus.lu_rdata_o), 64'(v.rdata));
    @(negedge clk);
    clear_in();
    #1;
    chk({nm, "_rvalid_after"}, 64'(bus.lu_rvalid_o), 64'd0);
    chk({nm, "_miss_req"}, 64'(bus.miss_req_o), 64'(!v.rvalid));
    chk({nm, "_miss_addr"}, 64'(bus.miss_addr_o), v.rvalid ? 64'd0 : 64'(v.maddr));
    if (!v.rvalid) begin
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk({nm, "_flush_miss_req"}, 64'(bus.miss_req_o), 64'd0);
      @(negedge clk);
      flush = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{12'h048, 44'h12,  8'h04, 1'b1, 64'hDA7A_0000_0000_0021, '0};
    vecs[1] = '{12'h040, 44'h33,  8'h01, 1'b1, 64'hDA7A_0000_0000_0000, '0};
    vecs[2] = '{12'h7F8, 44'hABC, 8'h80, 1'b1, 64'hDA7A_0000_0000_0071, '0};
    vecs[3] = '{12'h010, 44'h7,   8'h10, 1'b1, 64'hDA7A_0000_0000_0040, '0};
    vecs[4] = '{12'h00C, 44'h9,   8'h02, 1'b1, 64'hDA7A_0000_0000_0011, '0};
    vecs[5] = '{12'h123, 44'h5,   8'h00, 1'b0, 64'h0, 56'h0000_0000_0051_23};
    vecs[6] = '{12'h048, 44'h12,  8'h06, 1'b1, 64'hDA7A_0000_0000_0011, '0};

    clear_in();
    bus.rdata_i  = lines_fill();
    bus.lu_req_i = 1'b1;
    bus.gnt_i    = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_lu_gnt", 64'(bus.lu_gnt_o), 64'd0);
    chk("rst_req", 64'(bus.req_o), 64'd0);
    chk("rst_miss_req", 64'(bus.miss_req_o), 64'd0);
    chk("rst_rvalid", 64'(bus.lu_rvalid_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_in();
    #1;
    chk("idle_req", 64'(bus.req_o), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Grant stall: request held, nothing accepted until the arbiter grants.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      clear_in();
      bus.lu_req_i  = 1'b1;
      bus.lu_addr_i = 12'h048;
      #1;
      chk($sformatf("stall%0d_lu_gnt", c), 64'(bus.lu_gnt_o), 64'd0);
      chk($sformatf("stall%0d_req", c), 64'(bus.req_o), 64'hFF);
    end
    grant_lookup("stall", 12'h048);
    @(negedge clk);
    clear_in();
    bus.lu_tag_i = 44'h12; bus.lu_tag_valid_i = 1'b1; bus.hit_way_i = 8'h04;
    #1;
    chk("stall_rvalid", 64'(bus.lu_rvalid_o), 64'd1);
    chk("stall_rdata", 64'(bus.lu_rdata_o), 64'hDA7A_0000_0000_0021);

    // Miss, refill, replay hit using the stored tag.
    grant_lookup("mr", 12'h048);
    @(negedge clk);
    clear_in();
    bus.lu_tag_i = 44'h12; bus.lu_tag_valid_i = 1'b1;
    #1;
    chk("mr_rvalid_miss", 64'(bus.lu_rvalid_o), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      clear_in();
      #1;
      chk($sformatf("mr%0d_miss_req", c), 64'(bus.miss_req_o), 64'd1);
      chk($sformatf("mr%0d_miss_addr", c), 64'(bus.miss_addr_o), 64'h0000_0000_0012_048);
    end
    @(negedge clk);
    clear_in(); bus.miss_gnt_i = 1'b1;
    #1;
    chk("mr_miss_req_gnt", 64'(bus.miss_req_o), 64'd1);
    @(negedge clk);
    clear_in();
    #1;
    chk("mr_wait_miss_req", 64'(bus.miss_req_o), 64'd0);
    chk("mr_wait_req", 64'(bus.req_o), 64'd0);
    @(negedge clk);
    clear_in(); bus.miss_done_i = 1'b1;
    #1;
    chk("mr_done_req", 64'(bus.req_o), 64'd0);
    @(negedge clk);
    clear_in();
    #1;
    chk("mr_replay_req", 64'(bus.req_o), 64'hFF);
    chk("mr_replay_addr", 64'(bus.addr_o), 64'h048);
    @(negedge clk);
    clear_in(); bus.gnt_i = 1'b1; bus.lu_req_i = 1'b1;
    #1;
    chk("mr_replay_lu_gnt", 64'(bus.lu_gnt_o), 64'd0);
    @(negedge clk);
    clear_in(); bus.lu_tag_i = 44'h77; bus.hit_way_i = 8'h04;
    #1;
    chk("mr_tag_o", 64'(bus.tag_o), 64'h12);
    chk("mr_rvalid", 64'(bus.lu_rvalid_o), 64'd1);
    chk("mr_rdata", 64'(bus.lu_rdata_o), 64'hDA7A_0000_0000_0021);

    // Late tag: array result dropped, tag captured later, replay hits.
    grant_lookup("lt", 12'h048);
    @(negedge clk);
    clear_in(); bus.hit_way_i = 8'h04;
    #1;
    chk("lt_no_rvalid", 64'(bus.lu_rvalid_o), 64'd0);
    @(negedge clk);
    clear_in();
    #1;
    chk("lt_wait_req", 64'(bus.req_o), 64'd0);
    @(negedge clk);
    clear_in(); bus.lu_tag_i = 44'h12; bus.lu_tag_valid_i = 1'b1;
    #1;
    chk("lt_tag_req", 64'(bus.req_o), 64'd0);
    @(negedge clk);
    clear_in(); bus.gnt_i = 1'b1;
    #1;
    chk("lt_replay_req", 64'(bus.req_o), 64'hFF);
    @(negedge clk);
    clear_in(); bus.lu_tag_i = 44'h99; bus.lu_tag_valid_i = 1'b1; bus.hit_way_i = 8'h04;
    #1;
    chk("lt_tag_o", 64'(bus.tag_o), 64'h12);
    chk("lt_rvalid", 64'(bus.lu_rvalid_o), 64'd1);
    chk("lt_rdata", 64'(bus.lu_rdata_o), 64'hDA7A_0000_0000_0021);

    // Kill while waiting for the refill: no replay, port free afterwards.
    grant_lookup("kw", 12'h100);
    @(negedge clk);
    clear_in(); bus.lu_tag_i = 44'h3; bus.lu_tag_valid_i = 1'b1;
    @(negedge clk);
    clear_in(); bus.miss_gnt_i = 1'b1;
    #1;
    chk("kw_miss_req", 64'(bus.miss_req_o), 64'd1);
    @(negedge clk);
    clear_in(); bus.lu_kill_i = 1'b1;
    @(negedge clk);
    clear_in();
    #1;
    chk("kw_wait_req", 64'(bus.req_o), 64'd0);
    @(negedge clk);
    clear_in(); bus.miss_done_i = 1'b1;
    @(negedge clk);
    clear_in();
    #1;
    chk("kw_no_replay", 64'(bus.req_o), 64'd0);
    chk("kw_no_rvalid", 64'(bus.lu_rvalid_o), 64'd0);
    grant_lookup("kw_next", 12'h048);
    @(negedge clk);
    clear_in(); bus.lu_tag_i = 44'h12; bus.lu_tag_valid_i = 1'b1; bus.hit_way_i = 8'h04;
    #1;
    chk("kw_next_rvalid", 64'(bus.lu_rvalid_o), 64'd1);

    // Flush while the miss request is pending.
    grant_lookup("fl", 12'h123);
    @(negedge clk);
    clear_in(); bus.lu_tag_i = 44'h5; bus.lu_tag_valid_i = 1'b1;
    @(negedge clk);
    clear_in();
    #1;
    chk("fl_miss_req", 64'(bus.miss_req_o), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_miss_req_after", 64'(bus.miss_req_o), 64'd0);
    grant_lookup("fl_next", 12'h040);
    @(negedge clk);
    clear_in(); bus.lu_tag_i = 44'h33; bus.lu_tag_valid_i = 1'b1; bus.hit_way_i = 8'h01;
    #1;
    chk("fl_next_rvalid", 64'(bus.lu_rvalid_o), 64'd1);
    chk("fl_next_rdata", 64'(bus.lu_rdata_o), 64'hDA7A_0000_0000_0000);
    @(negedge clk);
    clear_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
